// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: controller states,
// counter/interrupt widths and the NOP instruction word used for flushes.
package pipe_ctrl_pkg;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned INT_W     = 3;
  localparam int unsigned INT_IDX_W = 2;

  // ADDI x0,x0,0: the word the pipeline registers load on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_IWAIT  = 2'd1,
    ST_DWAIT  = 2'd2,
    ST_INTACK = 2'd3
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder for the active-low interrupt lines.
//   oint_n : interrupt lines, active low (all ones = none pending)
//   any_c  : at least one line asserted
//   idx_c  : index of the lowest-numbered asserted line (line 0 wins)
module int_prio_enc
  import pipe_ctrl_pkg::*;
(
  input  logic [INT_W-1:0]     oint_n,
  output logic                 any_c,
  output logic [INT_IDX_W-1:0] idx_c
);

  always_comb begin
    any_c = (oint_n != {INT_W{1'b1}});
    idx_c = INT_IDX_W'(0);
    if (oint_n[0]) begin
      if (!oint_n[1]) begin
        idx_c = INT_IDX_W'(1);
      end else if (!oint_n[2]) begin
        idx_c = INT_IDX_W'(2);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: memory wait freezes with timeout,
// branch flushes, load-use stalls and single-shot interrupt acceptance.
//   clk, rst              : clock, synchronous active-high reset
//   ACKI_n, ACKD_n        : instruction / data memory acknowledge (active low)
//   OINT_n                : external interrupt lines (active low)
//   if_id_rs1/rs2         : source registers of the instruction in ID
//   id_ex_rd/mem_read     : destination and load flag of the instruction in EX
//   pc_src                : branch/jump taken (EX)
//   ex_mem_req            : instruction in MEM accesses data memory
//   hold_pc, freeze       : hold PC+IF/ID, hold ID/EX..MEM/WB
//   flush_id, flush_ex    : load NOP into IF/ID, ID/EX
//   int_req, int_idx      : trap-vector request and accepted line
//   IACK_n                : interrupt acknowledge pulse (active low)
//   bus_err               : sticky memory timeout flag
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ACKI_n,
  input  logic                 ACKD_n,
  input  logic [INT_W-1:0]     OINT_n,
  input  logic [4:0]           if_id_rs1,
  input  logic [4:0]           if_id_rs2,
  input  logic [4:0]           id_ex_rd,
  input  logic                 id_ex_mem_read,
  input  logic                 pc_src,
  input  logic                 ex_mem_req,
  output logic                 hold_pc,
  output logic                 freeze,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 int_req,
  output logic [INT_IDX_W-1:0] int_idx,
  output logic                 IACK_n,
  output logic                 bus_err
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   armed_q, armed_d;
  logic                   bus_err_q, bus_err_d;
  logic [INT_IDX_W-1:0]   int_idx_q, int_idx_d;
  logic                   int_any_c;
  logic [INT_IDX_W-1:0]   int_enc_c;
  logic                   stall, load_use;

  int_prio_enc u_int_prio_enc (
    .oint_n (OINT_n),
    .any_c  (int_any_c),
    .idx_c  (int_enc_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      bus_err_q <= 1'b0;
      int_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      bus_err_q <= bus_err_d;
      int_idx_q <= int_idx_d;
    end
  end

  // Next state and per-cycle control outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    bus_err_d = bus_err_q;
    int_idx_d = int_idx_q;
    stall     = 1'b0;
    hold_pc   = 1'b0;
    freeze    = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    int_req   = 1'b0;
    int_idx   = int_idx_q;
    IACK_n    = 1'b1;
    cnt_inc   = cnt_q + CNT_W'(1);
    load_use  = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

    // Re-arm only once all lines are released, so a held line fires once
    if (OINT_n == {INT_W{1'b1}}) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        cnt_d = '0;
        if (ex_mem_req && ACKD_n) begin
          state_d = ST_DWAIT;
          stall   = 1'b1;
        end else if (ACKI_n) begin
          state_d = ST_IWAIT;
          stall   = 1'b1;
        end
      end
      ST_DWAIT, ST_IWAIT: begin
        if ((state_q == ST_DWAIT) ? !ACKD_n : !ACKI_n) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          bus_err_d = 1'b1;
          stall     = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          stall = 1'b1;
        end
      end
      ST_INTACK: begin
        IACK_n  = 1'b0;
        armed_d = 1'b0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Priority: wait > branch > interrupt > load-use
    if (stall) begin
      hold_pc = 1'b1;
      freeze  = 1'b1;
    end else if (pc_src) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if ((state_q == ST_RUN) && armed_q && int_any_c) begin
      int_req   = 1'b1;
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      int_idx   = int_enc_c;
      int_idx_d = int_enc_c;
      state_d   = ST_INTACK;
    end else if (load_use) begin
      hold_pc  = 1'b1;
      flush_ex = 1'b1;
    end

    // Reset silences every control output, including a pending IACK_n
    if (rst) begin
      hold_pc  = 1'b0;
      freeze   = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      int_req  = 1'b0;
      int_idx  = int_idx_q;
      IACK_n   = 1'b1;
    end
  end

  assign bus_err = bus_err_q;

endmodule
